s_add_err_monitor16: RTL and testbench

- Sequential error-statistics collector that sits directly downstream of the generated 16-bit signed adder (17-bit result).
- Per accepted sample it takes operands a/b and the adder result dut_out, and computes the exact signed sum internally.
- Accumulates error count, sum of absolute error and worst-case absolute error over a programmed number of samples.
- Used in hardware evaluation benches for exact and approximate adder variants.

---
 rtl/s_add_err_monitor16.sv | 157 +++++++++++++++
 tb/tb_s_add_err_monitor16.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s_add_err_monitor16.sv
// s_add_err_monitor16: error statistics collector behind a 16-bit signed adder.
// Optional squared-error accumulator built when S_ADD_ERR_MON_SQ_EN is defined.
module s_add_err_monitor16 #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 48,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   n_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH:0]     dut_out,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   err_count,
  output logic [ACC_W-1:0]   sum_abs_err,
  output logic [WIDTH:0]     max_abs_err,
  output logic               acc_ovf,
  output logic [2*WIDTH+31:0] sum_sq_err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] remain;
  logic             s1_valid;
  logic [WIDTH:0]   s1_abs;
  logic             s1_nz;
  logic             accept;
  logic             go;
  logic             sq_sat;
  logic [WIDTH:0]   exact;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   abs_v;
  logic [ACC_W:0]   sum_ext;

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN) | (state == DRAIN);
  assign done     = (state == DONE);
  assign accept   = in_valid & in_ready;
  assign go       = start & ((state == IDLE) | (state == DONE));

  // |diff| never exceeds 2^(WIDTH+1)-1, so the low bits suffice.
  assign exact = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  assign diff  = {dut_out[WIDTH], dut_out} - {exact[WIDTH], exact};
  assign abs_v = diff[WIDTH+1] ? (~diff[WIDTH:0] + 1'b1) : diff[WIDTH:0];

  assign sum_ext = {1'b0, sum_abs_err} + (ACC_W+1)'(s1_abs);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        if (start)
          state_nx = (n_samples == '0) ? DONE : RUN;
      end
      RUN: begin
        if (accept && remain == CNT_W'(1))
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (!s1_valid)
          state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Remaining count and stage-1 capture of the per-sample error.
  always_ff @(posedge clk) begin
    if (rst) begin
      remain   <= '0;
      s1_valid <= 1'b0;
      s1_abs   <= '0;
      s1_nz    <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (go)
        remain <= n_samples;
      else if (accept)
        remain <= remain - 1'b1;
      if (accept) begin
        s1_abs <= abs_v;
        s1_nz  <= |diff;
      end
    end
  end

  // Statistics accumulate one edge after the sample is accepted.
  always_ff @(posedge clk) begin
    if (rst || go) begin
      err_count   <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
      acc_ovf     <= 1'b0;
    end else if (s1_valid) begin
      if (s1_nz)
        err_count <= err_count + 1'b1;
      if (s1_abs > max_abs_err)
        max_abs_err <= s1_abs;
      if (sum_ext[ACC_W])
        sum_abs_err <= '1;
      else
        sum_abs_err <= sum_ext[ACC_W-1:0];
      if (sum_ext[ACC_W] || sq_sat)
        acc_ovf <= 1'b1;
    end
  end

`ifdef S_ADD_ERR_MON_SQ_EN
  localparam int SQ_W = 2*WIDTH+2;
  localparam int SS_W = 2*WIDTH+32;

  logic [SQ_W-1:0] s1_sq;
  logic [SS_W-1:0] sq_acc;
  logic [SS_W:0]   sq_ext;

  assign sq_ext     = {1'b0, sq_acc} + (SS_W+1)'(s1_sq);
  assign sq_sat     = sq_ext[SS_W];
  assign sum_sq_err = sq_acc;

  // Stage-1 square of the absolute error.
  always_ff @(posedge clk) begin
    if (rst)         s1_sq <= '0;
    else if (accept) s1_sq <= SQ_W'(abs_v) * SQ_W'(abs_v);
  end

  // Saturating squared-error accumulator.
  always_ff @(posedge clk) begin
    if (rst || go)
      sq_acc <= '0;
    else if (s1_valid)
      sq_acc <= sq_sat ? '1 : sq_ext[SS_W-1:0];
  end
`else
  assign sq_sat     = 1'b0;
  assign sum_sq_err = '0;
`endif

endmodule

// File: tb/tb_s_add_err_monitor16.sv
// tb_s_add_err_monitor16: table, directed and random checks of the monitor.
// Reference model works on plain integers from the arithmetic rules.
module tb_s_add_err_monitor16;
  localparam int W  = 16;
  localparam int AW = 48;
  localparam int CW = 32;
  localparam longint ACC_MAX = (64'sd1 <<< 48) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] n_samples;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W:0]    dut_out;
  logic          busy;
  logic          done;
  logic [CW-1:0] err_count;
  logic [AW-1:0] sum_abs_err;
  logic [W:0]    max_abs_err;
  logic          acc_ovf;
  logic [2*W+31:0] sum_sq_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  s_add_err_monitor16 dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .dut_out(dut_out), .busy(busy), .done(done),
    .err_count(err_count), .sum_abs_err(sum_abs_err),
    .max_abs_err(max_abs_err), .acc_ovf(acc_ovf),
    .sum_sq_err(sum_sq_err)
  );

  typedef struct {
    int     n;
    int     sa[4];
    int     sb[4];
    int     sd[4];
    longint e_err;
    longint e_sum;
    longint e_max;
    longint e_sq;
  } vec_t;

  vec_t tbl[4];
  int qa[$];
  int qb[$];
  int qd[$];

  longint m_err, m_sum, m_max, m_sq;
  bit     m_ovf;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sq_exp(input longint v);
`ifdef S_ADD_ERR_MON_SQ_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic m_reset();
    m_err = 0; m_sum = 0; m_max = 0; m_sq = 0; m_ovf = 0;
  endtask

  task automatic model(input int av, input int bv, input int dv);
    longint ex, df, ab;
    ex = longint'(av) + longint'(bv);
    df = longint'(dv) - ex;
    ab = (df < 0) ? -df : df;
    if (df != 0) m_err++;
    if (m_sum + ab > ACC_MAX) begin
      m_sum = ACC_MAX;
      m_ovf = 1;
    end else begin
      m_sum = m_sum + ab;
    end
    if (ab > m_max) m_max = ab;
    m_sq = m_sq + ab * ab;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_err"}, 64'(err_count), 64'(m_err));
    chk({tag, "_sum"}, 64'(sum_abs_err), 64'(m_sum));
    chk({tag, "_max"}, 64'(max_abs_err), 64'(m_max));
    chk({tag, "_ovf"}, 64'(acc_ovf), 64'(m_ovf));
    chk({tag, "_sq"}, 64'(sum_sq_err), 64'(sq_exp(m_sq)));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_rdy"}, 64'(in_ready), 64'(0));
    chk({tag, "_err"}, 64'(err_count), 64'(0));
    chk({tag, "_sum"}, 64'(sum_abs_err), 64'(0));
    chk({tag, "_max"}, 64'(max_abs_err), 64'(0));
    chk({tag, "_ovf"}, 64'(acc_ovf), 64'(0));
    chk({tag, "_sq"}, 64'(sum_sq_err), 64'(0));
  endtask

  task automatic gen(input int n);
    logic signed [15:0] ta, tb;
    logic signed [16:0] td;
    int ex, mode, off;
    qa.delete(); qb.delete(); qd.delete();
    for (int i = 0; i < n; i++) begin
      ta = 16'($urandom);
      tb = 16'($urandom);
      ex = int'(ta) + int'(tb);
      mode = int'($urandom_range(3));
      off = 0;
      if (mode == 1) off = int'($urandom_range(20)) - 10;
      if (mode == 3) off = int'($urandom_range(131071)) - 65535;
      td = 17'(ex + off);
      if (mode == 2) td = 17'($urandom);
      qa.push_back(int'(ta));
      qb.push_back(int'(tb));
      qd.push_back(int'(td));
    end
  endtask

  // bub < 0 takes in_valid from vmask bit per cycle; poke pulses start mid-run
  task automatic run(input int n, input int bub, input logic [31:0] vmask,
                     input bit poke, input string tag);
    int idx, cyc;
    m_reset();
    @(negedge clk);
    n_samples = CW'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 2000) begin
      if (bub < 0) in_valid = vmask[cyc % 32];
      else in_valid = (int'($urandom_range(99)) >= bub);
      a = 16'(qa[idx]);
      b = 16'(qb[idx]);
      dut_out = 17'(qd[idx]);
      if (poke && idx == 1) begin
        start = 1'b1;
        n_samples = CW'(n + 7);
      end
      chk({tag, "_busy_run"}, 64'(busy), 64'(1));
      if (in_valid && in_ready) begin
        model(qa[idx], qb[idx], qd[idx]);
        idx++;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    if (idx < n) chk({tag, "_accept_timeout"}, 64'(idx), 64'(n));
    chk({tag, "_k0_done"}, 64'(done), 64'(0));
    chk({tag, "_k0_busy"}, 64'(busy), 64'(1));
    chk({tag, "_k0_rdy"}, 64'(in_ready), 64'(0));
    @(negedge clk);
    chk({tag, "_k1_done"}, 64'(done), 64'(0));
    @(negedge clk);
    chk({tag, "_k2_done"}, 64'(done), 64'(1));
    chk({tag, "_k2_busy"}, 64'(busy), 64'(0));
    chk_model(tag);
  endtask

  initial begin
    tbl[0].n = 4;
    tbl[0].sa = '{1, -1, 32767, -32768};
    tbl[0].sb = '{2, -1, 32767, -32768};
    tbl[0].sd = '{3, -2, 65534, -65536};
    tbl[0].e_err = 0; tbl[0].e_sum = 0; tbl[0].e_max = 0; tbl[0].e_sq = 0;

    tbl[1].n = 4;
    tbl[1].sa = '{10, 5, 100, 0};
    tbl[1].sb = '{20, -7, 100, 0};
    tbl[1].sd = '{33, -7, 200, 65535};
    tbl[1].e_err = 3; tbl[1].e_sum = 65543; tbl[1].e_max = 65535;
    tbl[1].e_sq = 64'd4294836259;

    tbl[2].n = 1;
    tbl[2].sa = '{-32768, 0, 0, 0};
    tbl[2].sb = '{-32768, 0, 0, 0};
    tbl[2].sd = '{65535, 0, 0, 0};
    tbl[2].e_err = 1; tbl[2].e_sum = 131071; tbl[2].e_max = 131071;
    tbl[2].e_sq = 64'd17179607041;

    tbl[3].n = 2;
    tbl[3].sa = '{1, 2, 0, 0};
    tbl[3].sb = '{1, 2, 0, 0};
    tbl[3].sd = '{5, 0, 0, 0};
    tbl[3].e_err = 2; tbl[3].e_sum = 7; tbl[3].e_max = 4; tbl[3].e_sq = 25;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    n_samples = '0; a = '0; b = '0; dut_out = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      qa.delete(); qb.delete(); qd.delete();
      for (int j = 0; j < tbl[i].n; j++) begin
        qa.push_back(tbl[i].sa[j]);
        qb.push_back(tbl[i].sb[j]);
        qd.push_back(tbl[i].sd[j]);
      end
      run(tbl[i].n, 0, '0, 1'b0, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_c_err", i), 64'(err_count), 64'(tbl[i].e_err));
      chk($sformatf("tbl%0d_c_sum", i), 64'(sum_abs_err), 64'(tbl[i].e_sum));
      chk($sformatf("tbl%0d_c_max", i), 64'(max_abs_err), 64'(tbl[i].e_max));
      chk($sformatf("tbl%0d_c_sq", i), 64'(sum_sq_err),
          64'(sq_exp(tbl[i].e_sq)));
    end

    // zero-length run from DONE clears the statistics left by the last run
    @(negedge clk);
    n_samples = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("n0_done", 64'(done), 64'(1));
      chk("n0_busy", 64'(busy), 64'(0));
      chk("n0_rdy", 64'(in_ready), 64'(0));
      chk("n0_err", 64'(err_count), 64'(0));
      chk("n0_sum", 64'(sum_abs_err), 64'(0));
      chk("n0_max", 64'(max_abs_err), 64'(0));
      chk("n0_sq", 64'(sum_sq_err), 64'(0));
      @(negedge clk);
    end

    gen(5);
    run(5, 20, '0, 1'b1, "poke");

    gen(3);
    run(3, -1, 32'h19, 1'b0, "bubble");

    for (int r = 0; r < 8; r++) begin
      gen(int'($urandom_range(1, 20)));
      run(qa.size(), int'($urandom_range(60)), '0, 1'b0,
          $sformatf("rnd%0d", r));
    end

    // reset in the middle of a run
    gen(5);
    @(negedge clk);
    n_samples = 5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    a = 16'(qa[0]); b = 16'(qb[0]); dut_out = 17'(qd[0] + 1);
    repeat (2) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'(1));
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("midrst");
    @(negedge clk);
    chk_zero("midrst_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
